// File: rtl/cnn_mac_seq.sv
// Sequenced 14s x 9s MAC over a runtime-length dot product, with bias, rescale and 14-bit saturation.
// Optional fused ReLU on the result when CNN_MAC_SEQ_RELU_EN is defined.
module cnn_mac_seq #(
  parameter int AW    = 10,
  parameter int ACC_W = 32,
  parameter int SHIFT = 6
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_ready,
  input  logic [AW-1:0]        len,
  input  logic signed [13:0]   bias,
  output logic [AW-1:0]        x_addr,
  output logic                 x_ce,
  input  logic signed [13:0]   x_q,
  output logic [AW-1:0]        w_addr,
  output logic                 w_ce,
  input  logic signed [8:0]    w_q,
  output logic signed [13:0]   res_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(8191);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-8192);

  logic [1:0]              state;
  logic [AW-1:0]           len_r;
  logic [AW-1:0]           addr;
  logic                    dvalid;
  logic                    pvalid;
  logic signed [22:0]      prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [13:0]      res_r;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [13:0]      res_next;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state  <= S_IDLE;
      len_r  <= '0;
      addr   <= '0;
      dvalid <= 1'b0;
      pvalid <= 1'b0;
      prod   <= '0;
      acc    <= '0;
      res_r  <= '0;
    end else begin
      dvalid <= (state == S_RUN);
      pvalid <= dvalid;
      if (dvalid)
        prod <= 23'(x_q) * 23'(w_q);

      if (state == S_IDLE && ap_start)
        acc <= ACC_W'(bias) <<< SHIFT;
      else if (pvalid)
        acc <= acc + ACC_W'(prod);

      case (state)
        S_IDLE: begin
          if (ap_start) begin
            len_r <= len;
            addr  <= '0;
            state <= (len == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (addr == len_r - AW'(1))
            state <= S_DRAIN;
          else
            addr <= addr + AW'(1);
        end
        S_DRAIN: begin
          // Once no fetch is outstanding, the last product lands in acc on this
          // same edge, so acc is final in DONE.
          if (!dvalid)
            state <= S_DONE;
        end
        default: begin
          res_r <= res_next;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    acc_sh   = acc >>> SHIFT;
    res_next = acc_sh[13:0];
    if (acc_sh > SAT_HI)
      res_next = 14'sd8191;
    else if (acc_sh < SAT_LO)
      res_next = -14'sd8192;
`ifdef CNN_MAC_SEQ_RELU_EN
    if (res_next[13])
      res_next = '0;
`endif
  end

  // The new result is forwarded during the DONE cycle so it is valid alongside
  // ap_done; the register holds it afterwards.
  assign res_out  = (state == S_DONE) ? res_next : res_r;
  assign ap_idle  = (state == S_IDLE);
  assign ap_done  = (state == S_DONE);
  assign ap_ready = (state == S_DONE);
  assign x_ce     = (state == S_RUN);
  assign w_ce     = (state == S_RUN);
  assign x_addr   = addr;
  assign w_addr   = addr;

endmodule
